tt_um_brs_peak_hold: RTL and testbench
======================================

# tt_um_brs_peak_hold

Windowed peak-hold stage that sits directly downstream of the BRS two-operand max block. It consumes that block's 8-bit max result as a stream of strobed samples and tracks the largest value over a programmable window of 4, 8, 16 or 32 samples. At the end of each window it publishes the peak on `uo_out` and raises a one-cycle done pulse. It uses the standard Tiny Tapeout top-level pinout.

## Interface
Parameters:
- none; window lengths are fixed at 4/8/16/32.

Ports:
- `clk`  input  1  clock; one clock domain.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `ena`  input  1  always 1 when powered; ignored.
- `ui_in`  input  8  sample data, unsigned (the upstream max result).
- `uio_in[0]`  input  1  sample strobe; asynchronous pin; a rising edge requests one sample.
- `uio_in[1]`  input  1  synchronous clear, active high.
- `uio_in[3:2]`  input  2  window select: N = 4 << sel, giving 4, 8, 16 or 32.
- `uio_in[7:4]`  input  4  unused.
- `uo_out`  output  8  published peak of the last completed window.
- `uio_out[4]`  output  1  `done`: one-cycle pulse on publish.
- `uio_out[5]`  output  1  `rise`: last published peak > the previously published peak.
- `uio_out[7:6]`  output  2  FSM state: 00 IDLE, 01 ACCUM, 10 DONE.
- `uio_out[3:0]`  output  4  constant 0.
- `uio_oe`  output  8  constant 8'hF0.

## Operation
- **Strobe path**
  - `uio_in[0]` passes through a 2-FF synchronizer (s1, s2) plus a delay flop s3.
  - The strobe is `s2 & ~s3`, so one sample is taken per rising edge, however long the pin stays high.
- **Comparison**
  - Unsigned 8-bit: `acc <= (sample > acc) ? sample : acc`.
  - Ties keep `acc` (no change).
- **Window counter**
  - 5-bit count of accepted samples.
  - `win_n` is latched from `uio_in[3:2]` on each window start: IDLE->ACCUM and DONE->ACCUM.
  - Changes to `uio_in[3:2]` mid-window are ignored until the next window.
- **FSM**
  - IDLE: on strobe -> ACCUM, with acc=sample, count=1, latch `win_n`. If N were 1 it would publish at once; N≥4, so this never occurs.
  - ACCUM: on strobe, update acc and count += 1.
    - If this is the N-th sample -> DONE.
    - At that same edge: `uo_out <= max(acc, sample)`, `rise <= (new peak > old uo_out)`.
  - DONE: one cycle, `done` = 1. Next edge -> ACCUM with acc=0, count=0, `win_n` relatched.
    - A strobe during DONE, which is unreachable given the minimum strobe spacing of 2 cycles, is accepted as sample 1 of the next window.
- **Clear** (`uio_in[1]`=1, sampled on `clk`)
  - From any state -> IDLE; acc, count, `uo_out` and `rise` are set to 0.
  - Clear beats a simultaneous strobe: that sample is dropped.
  - The synchronizer flops are not cleared.
- **Reset** (`rst_n`=0, asynchronous)
  - All flops go to 0, including the synchronizer; state IDLE.
  - `uo_out`=0, `done`=0, `rise`=0, `uio_out[7:6]`=00, immediately and without a clock edge.

## Timing
- Strobe latency:
  - pin high captured by s1 at edge E;
  - s2 high after E+1, strobe asserted in the cycle after E+1;
  - `ui_in` is captured at edge E+2.
- `ui_in` must be stable from edge E through edge E+2.
- Minimum strobe period: pin high ≥1 cycle, low ≥1 cycle, so accepted samples are ≥2 cycles apart.
- Publish: `uo_out`, `rise`, and state=DONE all update at edge E+2 of the N-th sample. `done` is high for exactly the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Rolling windows are back-to-back; only the DONE cycle separates them.

## Test plan
1. **Reset**
   - Stimulus: assert `rst_n`=0 mid-ACCUM, between clock edges.
   - Required: `uo_out`=0, `uio_out`=8'h00 and `uio_oe`=8'hF0 immediately; after release, state=00.
2. **N=4 window**
   - Stimulus: sel=00, samples 10, 200, 35, 199.
   - Required: `uo_out`=200 and `rise`=1; `done` high for exactly 1 cycle; state goes 10 then 01.
3. **Ties and non-rising peak**
   - Stimulus: next window 50, 50, 50, 50.
   - Required: `uo_out`=50, `rise`=0, one `done` pulse.
4. **Select latched per window**
   - Stimulus: change sel to 11 after the 2nd sample of a 4-sample window.
   - Required: that window publishes after 4 samples. The next window needs 32 samples; with 0xFF as sample 32 it publishes `uo_out`=8'hFF, `rise`=1.
5. **Clear with simultaneous strobe**
   - Stimulus: clear in the strobe cycle during ACCUM.
   - Required: state=00, `uo_out`=0, `rise`=0; the sample is dropped. A new window starts on the next strobe.
6. **Long strobe**
   - Stimulus: hold `uio_in[0]` high for 10 cycles.
   - Required: exactly one sample accepted (count +1); `ui_in` is captured 2 edges after s1 first samples high.

Source files
------------

// File: rtl/tt_um_brs_peak_hold.sv
// Windowed peak-hold: tracks the largest strobed 8-bit sample over a window of
// 4/8/16/32 samples and publishes it with a one-cycle done pulse.
module tt_um_brs_peak_hold (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [7:0]  acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  uo_q, uo_d;
  logic        rise_q, rise_d;
  logic        done_q, done_d;

  logic        strobe_s;
  logic        clr_s;
  logic [1:0]  sel_in_s;
  logic [7:0]  max_s;
  logic [4:0]  last_s;
  logic        unused_s;

  assign strobe_s = s2_q & ~s3_q;
  assign clr_s    = uio_in[1];
  assign sel_in_s = uio_in[3:2];
  assign max_s    = (ui_in > acc_q) ? ui_in : acc_q;
  assign unused_s = &{1'b0, ena, uio_in[7:4]};

  // Strobe pin synchronizer plus edge-detect delay flop; untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= uio_in[0];
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Index of the last sample in the latched window (N-1).
  always_comb begin
    last_s = 5'd31;
    case (sel_q)
      2'b00:   last_s = 5'd3;
      2'b01:   last_s = 5'd7;
      2'b10:   last_s = 5'd15;
      default: last_s = 5'd31;
    endcase
  end

  // Window FSM and datapath next state; clear overrides any strobe.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    uo_d    = uo_q;
    rise_d  = rise_q;
    done_d  = 1'b0;
    if (clr_s) begin
      state_d = IDLE;
      acc_d   = 8'd0;
      cnt_d   = 5'd0;
      uo_d    = 8'd0;
      rise_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe_s) begin
            state_d = ACCUM;
            acc_d   = ui_in;
            cnt_d   = 5'd1;
            sel_d   = sel_in_s;
          end else begin
            state_d = IDLE;
          end
        end
        ACCUM: begin
          if (strobe_s) begin
            acc_d = max_s;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == last_s) begin
              state_d = DONE;
              uo_d    = max_s;
              rise_d  = (max_s > uo_q);
              done_d  = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        DONE: begin
          state_d = ACCUM;
          sel_d   = sel_in_s;
          // Only reachable with strobes closer than the minimum spacing.
          if (strobe_s) begin
            acc_d = ui_in;
            cnt_d = 5'd1;
          end else begin
            acc_d = 8'd0;
            cnt_d = 5'd0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = 8'd0;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 8'd0;
      cnt_q   <= 5'd0;
      sel_q   <= 2'b00;
      uo_q    <= 8'd0;
      rise_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      uo_q    <= uo_d;
      rise_q  <= rise_d;
      done_q  <= done_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {state_q, rise_q, done_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_brs_peak_hold.sv
// Randomized self-checking bench for tt_um_brs_peak_hold against a
// window/peak reference model.
module tb_tt_um_brs_peak_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       pin, clr;
  logic [1:0] sel;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: window progress and last published peak
  bit m_active;
  int m_len, m_cnt, m_peak, m_pub;
  bit m_rise;

  assign uio_in = {4'b0000, sel, clr, pin};

  always #5 clk = ~clk;

  tt_um_brs_peak_hold dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_active = 1'b0;
    m_cnt = 0; m_peak = 0; m_pub = 0; m_rise = 1'b0; m_len = 4;
  endtask

  // Account one accepted sample in the model and check DUT outputs.
  task automatic model_sample(input logic [7:0] v, input string tag);
    if (!m_active) begin
      m_active = 1'b1;
      m_len = 4 << sel;
      m_cnt = 0;
      m_peak = 0;
    end
    m_cnt++;
    if (int'(v) > m_peak) m_peak = int'(v);
    if (m_cnt == m_len) begin
      m_rise = (m_peak > m_pub);
      m_pub = m_peak;
      n_tests++;
      if (uo_out !== m_pub[7:0] || uio_out[5] !== m_rise || uio_out[4] !== 1'b1 ||
          uio_out[7:6] !== 2'b10 || uio_out[3:0] !== 4'h0) begin
        n_fail++;
        $display("FAIL %s publish: got uo=%0d uio_out=%h, want uo=%0d rise=%0b done=1 st=10",
                 tag, uo_out, uio_out, m_pub, m_rise);
      end
      tick;
      n_tests++;
      if (uio_out[4] !== 1'b0 || uio_out[7:6] !== 2'b01 || uo_out !== m_pub[7:0]) begin
        n_fail++;
        $display("FAIL %s after_done: got uo=%0d uio_out=%h, want uo=%0d done=0 st=01",
                 tag, uo_out, uio_out, m_pub);
      end
      m_active = 1'b1;
      m_len = 4 << sel;
      m_cnt = 0;
      m_peak = 0;
    end else begin
      n_tests++;
      if (uio_out[4] !== 1'b0 || uio_out[7:6] !== 2'b01 || uo_out !== m_pub[7:0] ||
          uio_out[5] !== m_rise) begin
        n_fail++;
        $display("FAIL %s accum: got uo=%0d uio_out=%h, want uo=%0d rise=%0b done=0 st=01",
                 tag, uo_out, uio_out, m_pub, m_rise);
      end
    end
  endtask

  // One-cycle pin pulse; returns one cycle after the capture edge (E+2).
  task automatic send_sample(input logic [7:0] v, input string tag);
    ui_in = v;
    pin = 1'b1;
    tick;
    pin = 1'b0;
    tick;
    tick;
    ui_in = ~v;
    model_sample(v, tag);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    pin = 1'b0; clr = 1'b0; sel = 2'b00; ui_in = 8'd0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    model_reset();
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if (uo_out !== 8'd0 || uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
      n_fail++;
      $display("FAIL reset_init: got uo=%h uio_out=%h oe=%h, want 00 00 F0", uo_out, uio_out, uio_oe);
    end
    sel = 2'b00;
    for (int i = 0; i < 4; i++) send_sample(8'(i * 40 + 30), "reset_pre");
    send_sample(8'd77, "reset_pre");
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (uo_out !== 8'd0 || uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
      n_fail++;
      $display("FAIL reset_async: got uo=%h uio_out=%h oe=%h, want 00 00 F0", uo_out, uio_out, uio_oe);
    end
    tick;
    rst_n = 1'b1;
    tick;
    model_reset();
    n_tests++;
    if (uio_out[7:6] !== 2'b00 || uo_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release: got st=%b uo=%h, want st=00 uo=00", uio_out[7:6], uo_out);
    end
  endtask

  task automatic test_n4;
    sel = 2'b00;
    send_sample(8'd10,  "n4");
    send_sample(8'd200, "n4");
    send_sample(8'd35,  "n4");
    send_sample(8'd199, "n4");
    n_tests++;
    if (uo_out !== 8'd200 || uio_out[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL n4_peak: got uo=%0d rise=%0b, want 200 1", uo_out, uio_out[5]);
    end
  endtask

  task automatic test_ties;
    for (int i = 0; i < 4; i++) send_sample(8'd50, "ties");
    n_tests++;
    if (uo_out !== 8'd50 || uio_out[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL ties_peak: got uo=%0d rise=%0b, want 50 0", uo_out, uio_out[5]);
    end
  endtask

  task automatic test_sel_latch;
    sel = 2'b00;
    send_sample(8'd7, "sel_latch");
    send_sample(8'd9, "sel_latch");
    sel = 2'b11;
    send_sample(8'd60, "sel_latch");
    send_sample(8'd3, "sel_latch");
    for (int i = 0; i < 31; i++) send_sample(8'($urandom_range(0, 254)), "sel32");
    send_sample(8'hFF, "sel32");
    n_tests++;
    if (uo_out !== 8'hFF || uio_out[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL sel32_peak: got uo=%h rise=%0b, want FF 1", uo_out, uio_out[5]);
    end
  endtask

  task automatic test_clear;
    send_sample(8'd90, "clear_pre");
    send_sample(8'd91, "clear_pre");
    ui_in = 8'd250;
    pin = 1'b1;
    tick;
    pin = 1'b0;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    model_reset();
    n_tests++;
    if (uio_out !== 8'h00 || uo_out !== 8'd0) begin
      n_fail++;
      $display("FAIL clear: got uo=%h uio_out=%h, want 00 00", uo_out, uio_out);
    end
    tick;
    n_tests++;
    if (uio_out[7:6] !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_idle: got st=%b, want 00", uio_out[7:6]);
    end
    sel = 2'b00;
    for (int i = 0; i < 4; i++) send_sample(8'($urandom_range(0, 120)), "clear_post");
  endtask

  task automatic test_long_strobe;
    ui_in = 8'd240;
    pin = 1'b1;
    tick; tick; tick;
    ui_in = 8'd250;
    for (int i = 0; i < 7; i++) tick;
    pin = 1'b0;
    tick;
    model_sample(8'd240, "long");
    for (int i = 0; i < 3; i++) send_sample(8'($urandom_range(0, 239)), "long_post");
    n_tests++;
    if (uo_out !== 8'd240) begin
      n_fail++;
      $display("FAIL long_peak: got uo=%0d, want 240", uo_out);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) send_sample(8'(m_peak), "rand_tie");
      else send_sample(8'($urandom), "rand");
    end
  endtask

  initial begin
    pin = 1'b0; clr = 1'b0; sel = 2'b00; ui_in = 8'd0; rst_n = 1'b0;
    model_reset();
    test_reset();
    test_n4();
    test_ties();
    test_sel_latch();
    test_clear();
    test_long_strobe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
